avm_pipeline_bridge: RTL and testbench
======================================

Name: avm_pipeline_bridge

Overview:
- Avalon-MM pipeline bridge between the wordcopy master port and the SDRAM controller slave.
- Registers every command through a 2-entry skid buffer, so waitrequest is registered on both sides.
- Caps outstanding reads at MAX_PENDING and re-registers read responses.
- Breaks the combinational waitrequest/readdata timing path between the copy engine and SDRAM without reordering traffic.

Parameters:
- ADDR_W, 32, address width on both sides
- DATA_W, 32, data width on both sides
- MAX_PENDING, 4, maximum reads issued to SDRAM and not yet returned (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_waitrequest  out  1  bridge cannot accept a command this cycle
- s_address  in  ADDR_W  upstream byte address
- s_read  in  1  upstream read request
- s_write  in  1  upstream write request
- s_writedata  in  DATA_W  upstream write data
- s_readdata  out  DATA_W  read data returned upstream
- s_readdatavalid  out  1  s_readdata valid this cycle
- m_waitrequest  in  1  SDRAM stalls the current command
- m_address  out  ADDR_W  SDRAM address
- m_read  out  1  SDRAM read request
- m_write  out  1  SDRAM write request
- m_writedata  out  DATA_W  SDRAM write data
- m_readdata  in  DATA_W  SDRAM read data
- m_readdatavalid  in  1  SDRAM read data valid
- pending  out  4  reads outstanding at SDRAM
- err_stale  out  1  sticky: readdatavalid arrived with pending==0

Behaviour:
- Reset, synchronous: during rst and on the cycle it is sampled, all outputs are 0 except s_waitrequest=1. The buffer empties, pending=0 and err_stale=0. The first cycle after rst deasserts has s_waitrequest=0.
- Upstream accept:
  - A command is accepted when (s_read|s_write) && !s_waitrequest.
  - s_read and s_write both high is illegal. Treat it as a write and set err_stale.
  - s_waitrequest is registered; it equals 1 when both buffer entries are occupied.
- Skid buffer:
  - Main entry drives the m_* outputs. Skid entry holds the command accepted in the cycle the main entry stalled.
  - FIFO order; reads and writes are never reordered.
  - Full buffer with a simultaneous pop: s_waitrequest stays 1 that cycle and drops to 0 the next.
- Issue to SDRAM:
  - The main entry is presented when valid and (write, or pending < MAX_PENDING).
  - A gated read holds m_read=0 and stalls the buffer. A write behind a gated read also waits, to preserve order.
  - Address, data and strobe stay stable while m_waitrequest=1.
  - The entry pops on (m_read|m_write) && !m_waitrequest.
- Latency:
  - Command accepted at upstream edge N appears on m_* at earliest in the cycle after edge N.
  - Response: m_readdatavalid at edge K gives s_readdatavalid=1 with s_readdata=m_readdata in the cycle after edge K, for exactly one cycle.
- pending counter:
  - +1 on read pop, -1 on m_readdatavalid. Both in the same cycle leaves it unchanged.
  - It never exceeds MAX_PENDING and never goes below 0.
- Stale response: m_readdatavalid with pending==0 is dropped (no s_readdatavalid), sets err_stale, and leaves pending at 0. Only rst clears err_stale.
- Reset mid-operation: buffered commands are discarded and not issued. Any in-flight SDRAM read is the SDRAM controller's responsibility, since it shares rst.
- No backpressure on responses: the s-side consumer must always accept s_readdatavalid, per Avalon.

Decomposition:
- Package avm_bridge_pkg:
  - typedef avm_cmd_t struct: is_write, address, writedata.
  - Constants DEFAULT_ADDR_W, DEFAULT_DATA_W, DEFAULT_MAX_PENDING.
- Sub-module avm_skid_buffer: 2-entry registered-ready buffer of avm_cmd_t with in_valid/in_ready/out_valid/out_ready.
- The top level holds the pending counter, issue gating, response register and error flag.

Test Plan:
- Reset then idle: rst high for 2 cycles, then low → s_waitrequest=1 during reset and 0 the cycle after. m_read=m_write=0, pending=0, err_stale=0.
- Single write: write addr 0xAAAA1110, data 0x12345678, m_waitrequest=0 → m_write=1 with the same addr/data exactly one cycle after acceptance, for one cycle.
- SDRAM stall: 3 back-to-back writes (0x1000/0x1004/0x1008) with m_waitrequest=1 for 5 cycles → s_waitrequest rises after 2 accepts. m_* holds 0x1000 stable. After release, all three issue in order; no loss or duplication.
- Pending cap: 6 reads, SDRAM returns data only after a 10-cycle delay → exactly 4 m_read pops then m_read=0 with pending=4. Each return of 0xFEFEFEFE frees one slot; 6 s_readdatavalid pulses arrive in order.
- Simultaneous: read pop and m_readdatavalid on the same edge at pending=2 → pending stays 2.
- Stale and reset: m_readdatavalid with pending=0 → no s_readdatavalid and err_stale=1. A later rst with 2 buffered writes → err_stale=0, pending=0, and neither write appears on m_write.

Source files
------------

// File: rtl/avm_bridge_pkg.sv
// -----------------------------------------------------------------------------
// avm_bridge_pkg
// Shared types and default parameters for the Avalon-MM pipeline bridge.
//   avm_cmd_t : one buffered command (write strobe, byte address, write data)
//               at the default bus widths. The bridge top re-declares the same
//               layout at its own widths and hands it to the skid buffer.
// -----------------------------------------------------------------------------
package avm_bridge_pkg;

    localparam int DEFAULT_ADDR_W      = 32;
    localparam int DEFAULT_DATA_W      = 32;
    localparam int DEFAULT_MAX_PENDING = 4;

    typedef struct packed {
        logic                      is_write;
        logic [DEFAULT_ADDR_W-1:0] address;
        logic [DEFAULT_DATA_W-1:0] writedata;
    } avm_cmd_t;

endpackage

// File: rtl/avm_skid_buffer.sv
// -----------------------------------------------------------------------------
// avm_skid_buffer
// Two-entry FIFO with a registered ready. The main entry feeds the output; the
// skid entry catches the command accepted while the main entry was stalled.
// in_ready is computed from the next occupancy, so a full buffer that pops
// keeps in_ready low for that cycle and raises it the cycle after.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_data    upstream command, taken when in_valid && in_ready
//   in_ready            registered: low only when both entries are occupied
//   out_valid/out_data  main entry
//   out_ready           consumer takes the main entry this cycle
// -----------------------------------------------------------------------------
module avm_skid_buffer
    import avm_bridge_pkg::*;
#(
    parameter type cmd_t = avm_cmd_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  cmd_t in_data,
    output logic in_ready,
    output logic out_valid,
    output cmd_t out_data,
    input  logic out_ready
);

    cmd_t main_q, main_d;
    cmd_t skid_q, skid_d;
    logic main_vld_q, main_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic in_ready_q, in_ready_d;
    logic push, pop;

    always_comb begin
        push       = in_valid && in_ready_q;
        pop        = main_vld_q && out_ready;
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;

        if (pop) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = 1'b0;
            end
        end

        // Push lands behind whatever remains after the pop, keeping FIFO order.
        if (push) begin
            if (!main_vld_d) begin
                main_d     = in_data;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = in_data;
                skid_vld_d = 1'b1;
            end
        end

        in_ready_d = !(main_vld_d && skid_vld_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld_q;
    assign out_data  = main_q;

endmodule

// File: rtl/avm_pipeline_bridge.sv
// -----------------------------------------------------------------------------
// avm_pipeline_bridge
// Avalon-MM pipeline bridge between the wordcopy master and the SDRAM slave.
// Commands pass through a 2-entry skid buffer (registered waitrequest on both
// sides), reads outstanding at SDRAM are capped at MAX_PENDING (1..15), and
// read responses are re-registered. Traffic is never reordered.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   s_*                              upstream slave port (from copy engine)
//   m_*                              downstream master port (to SDRAM)
//   pending                          reads issued to SDRAM and not yet returned
//   err_stale                        sticky: response with nothing pending, or
//                                    read and write requested together
// -----------------------------------------------------------------------------
module avm_pipeline_bridge
    import avm_bridge_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int MAX_PENDING = DEFAULT_MAX_PENDING
) (
    input  logic              clk,
    input  logic              rst,
    output logic              s_waitrequest,
    input  logic [ADDR_W-1:0] s_address,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [DATA_W-1:0] s_writedata,
    output logic [DATA_W-1:0] s_readdata,
    output logic              s_readdatavalid,
    input  logic              m_waitrequest,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    output logic [3:0]        pending,
    output logic              err_stale
);

    localparam logic [3:0] MAX_P = 4'(MAX_PENDING);

    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
    } cmd_t;

    cmd_t in_cmd, out_cmd;
    logic in_valid, in_ready, out_valid, out_ready;
    logic issue, rd_pop, rsp_ok, accept;

    logic [3:0]        pending_q, pending_d;
    logic              err_q, err_d;
    logic              rdv_q, rdv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    avm_skid_buffer #(
        .cmd_t (cmd_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_cmd),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_cmd),
        .out_ready (out_ready)
    );

    always_comb begin
        // Read+write together is taken as a write (and flagged below).
        in_valid           = s_read || s_write;
        in_cmd.is_write    = s_write;
        in_cmd.address     = s_address;
        in_cmd.writedata   = s_writedata;
        accept             = in_valid && in_ready;

        // A gated read at the head blocks everything behind it, writes too.
        issue     = out_valid && (out_cmd.is_write || (pending_q < MAX_P));
        out_ready = issue && !m_waitrequest;
        rd_pop    = out_ready && !out_cmd.is_write;
        rsp_ok    = m_readdatavalid && (pending_q != 4'd0);

        pending_d = pending_q;
        if (rd_pop && !rsp_ok) begin
            pending_d = pending_q + 4'd1;
        end else if (!rd_pop && rsp_ok) begin
            pending_d = pending_q - 4'd1;
        end

        err_d = err_q
              || (m_readdatavalid && (pending_q == 4'd0))
              || (accept && s_read && s_write);

        rdv_d   = rsp_ok;
        rdata_d = rsp_ok ? m_readdata : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            err_q     <= 1'b0;
            rdv_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
            rdv_q     <= rdv_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_waitrequest   = !in_ready;
    assign s_readdata      = rdata_q;
    assign s_readdatavalid = rdv_q;
    assign m_address       = out_cmd.address;
    assign m_writedata     = out_cmd.writedata;
    assign m_read          = issue && !out_cmd.is_write;
    assign m_write         = issue && out_cmd.is_write;
    assign pending         = pending_q;
    assign err_stale       = err_q;

endmodule

// File: tb/tb_avm_pipeline_bridge.sv
// -----------------------------------------------------------------------------
// tb_avm_pipeline_bridge
// Scoreboarded bench for avm_pipeline_bridge. Accepted upstream commands are
// queued and matched against SDRAM-side pops; SDRAM responses are queued and
// matched against upstream readdatavalid. A reference pending count and error
// flag are kept alongside.
// -----------------------------------------------------------------------------
module tb_avm_pipeline_bridge;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_waitrequest;
    logic [AW-1:0] s_address;
    logic          s_read;
    logic          s_write;
    logic [DW-1:0] s_writedata;
    logic [DW-1:0] s_readdata;
    logic          s_readdatavalid;
    logic          m_waitrequest;
    logic [AW-1:0] m_address;
    logic          m_read;
    logic          m_write;
    logic [DW-1:0] m_writedata;
    logic [DW-1:0] m_readdata;
    logic          m_readdatavalid;
    logic [3:0]    pending;
    logic          err_stale;

    avm_pipeline_bridge #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_PENDING (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_waitrequest   (s_waitrequest),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_waitrequest   (m_waitrequest),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .pending         (pending),
        .err_stale       (err_stale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_cmd_t;

    exp_cmd_t      cmd_q[$];
    logic [DW-1:0] rsp_q[$];
    exp_cmd_t      mon_e;
    logic [DW-1:0] mon_r;
    bit            mon_inc;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int mdl_pend = 0;
    bit mdl_err = 1'b0;
    int m_rd_pops = 0;
    int m_wr_pops = 0;
    int s_rdv_cnt = 0;

    // Scoreboard / reference model, evaluated mid-cycle on settled values.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (pending !== 4'(mdl_pend)) begin
                errors++;
                $display("FAIL pending_track: got %0d required %0d at %0t", pending, mdl_pend, $time);
            end
            checks++;
            if (err_stale !== mdl_err) begin
                errors++;
                $display("FAIL err_track: got %b required %b at %0t", err_stale, mdl_err, $time);
            end
            if (s_readdatavalid === 1'b1) begin
                s_rdv_cnt++;
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got readdata %h required no readdatavalid at %0t", s_readdata, $time);
                end else begin
                    mon_r = rsp_q.pop_front();
                    if (s_readdata !== mon_r) begin
                        errors++;
                        $display("FAIL rsp_data: got %h required %h at %0t", s_readdata, mon_r, $time);
                    end
                end
            end

            if (rst === 1'b1) begin
                cmd_q.delete();
                rsp_q.delete();
                mdl_pend = 0;
                mdl_err  = 1'b0;
            end else begin
                mon_inc = 1'b0;
                if ((m_read === 1'b1 || m_write === 1'b1) && m_waitrequest === 1'b0) begin
                    checks++;
                    if (cmd_q.size() == 0) begin
                        errors++;
                        $display("FAIL cmd_unexpected: got rd=%b wr=%b addr %h required no command at %0t",
                                 m_read, m_write, m_address, $time);
                    end else begin
                        mon_e = cmd_q.pop_front();
                        if (m_write !== mon_e.is_write || m_read !== !mon_e.is_write ||
                            m_address !== mon_e.addr ||
                            (mon_e.is_write && m_writedata !== mon_e.data)) begin
                            errors++;
                            $display("FAIL cmd_order: got wr=%b addr %h data %h required wr=%b addr %h data %h at %0t",
                                     m_write, m_address, m_writedata, mon_e.is_write, mon_e.addr, mon_e.data, $time);
                        end
                    end
                    if (m_read === 1'b1) begin
                        m_rd_pops++;
                        mon_inc = 1'b1;
                    end else begin
                        m_wr_pops++;
                    end
                end
                if (m_readdatavalid === 1'b1) begin
                    if (mdl_pend == 0) begin
                        mdl_err = 1'b1;
                    end else begin
                        rsp_q.push_back(m_readdata);
                        mdl_pend--;
                    end
                end
                if (mon_inc) mdl_pend++;
                if ((s_read || s_write) && s_waitrequest === 1'b0) begin
                    cmd_q.push_back('{s_write, s_address, s_writedata});
                    if (s_read && s_write) mdl_err = 1'b1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc;
        s_read      = rd;
        s_write     = wr;
        s_address   = a;
        s_writedata = d;
        for (int i = 0; i < 200; i++) begin
            acc = (s_waitrequest === 1'b0);
            cyc();
            if (acc) begin
                s_read  = 1'b0;
                s_write = 1'b0;
                return;
            end
        end
        s_read  = 1'b0;
        s_write = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout: addr %h not accepted, required acceptance within 200 cycles", a);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        mon_en = 1'b1;
        cyc();
        checks++;
        if (s_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_waitrequest: got %b required 1", s_waitrequest);
        end
        checks++;
        if (m_read !== 1'b0 || m_write !== 1'b0 || s_readdatavalid !== 1'b0 ||
            m_address !== '0 || s_readdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b wr=%b rdv=%b addr=%h rdata=%h required all 0",
                     m_read, m_write, s_readdatavalid, m_address, s_readdata);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (s_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got waitrequest %b required 0", s_waitrequest);
        end
        checks++;
        if (m_read !== 1'b0 || m_write !== 1'b0 || pending !== 4'd0 || err_stale !== 1'b0) begin
            errors++;
            $display("FAIL idle_state: got rd=%b wr=%b pending=%0d err=%b required 0 0 0 0",
                     m_read, m_write, pending, err_stale);
        end
    endtask

    task automatic test_single_write();
        int wp;
        m_waitrequest = 1'b0;
        wp = m_wr_pops;
        send(1'b0, 1'b1, 32'hAAAA1110, 32'h12345678);
        checks++;
        if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 32'hAAAA1110 || m_writedata !== 32'h12345678) begin
            errors++;
            $display("FAIL single_write_issue: got wr=%b addr %h data %h required wr=1 addr aaaa1110 data 12345678",
                     m_write, m_address, m_writedata);
        end
        cyc();
        checks++;
        if (m_write !== 1'b0) begin
            errors++;
            $display("FAIL single_write_once: got m_write %b required 0", m_write);
        end
        checks++;
        if (m_wr_pops - wp != 1) begin
            errors++;
            $display("FAIL single_write_count: got %0d writes required 1", m_wr_pops - wp);
        end
    endtask

    task automatic test_sdram_stall();
        int wp;
        wp = m_wr_pops;
        m_waitrequest = 1'b1;
        fork
            begin
                send(1'b0, 1'b1, 32'h1000, 32'hD0D0_0000);
                send(1'b0, 1'b1, 32'h1004, 32'hD0D0_0004);
                send(1'b0, 1'b1, 32'h1008, 32'hD0D0_0008);
            end
            begin
                for (int i = 1; i <= 5; i++) begin
                    cyc();
                    checks++;
                    if (m_write !== 1'b1 || m_address !== 32'h1000 || m_writedata !== 32'hD0D0_0000) begin
                        errors++;
                        $display("FAIL stall_hold: cycle %0d got wr=%b addr %h data %h required wr=1 addr 1000 data d0d00000",
                                 i, m_write, m_address, m_writedata);
                    end
                    if (i == 2) begin
                        checks++;
                        if (s_waitrequest !== 1'b1) begin
                            errors++;
                            $display("FAIL stall_waitrequest: got %b required 1 after two accepts", s_waitrequest);
                        end
                    end
                end
                m_waitrequest = 1'b0;
            end
        join
        repeat (4) cyc();
        checks++;
        if (m_wr_pops - wp != 3 || cmd_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: got %0d writes, %0d queued required 3 writes, 0 queued",
                     m_wr_pops - wp, cmd_q.size());
        end
    endtask

    task automatic test_pending_cap();
        int rp;
        int rc;
        m_waitrequest = 1'b0;
        rp = m_rd_pops;
        rc = s_rdv_cnt;
        for (int k = 0; k < 6; k++) send(1'b1, 1'b0, 32'(32'h2000 + k * 4), 32'h0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (m_read !== 1'b0) begin
                errors++;
                $display("FAIL cap_gate: cycle %0d got m_read %b required 0", i, m_read);
            end
        end
        checks++;
        if (m_rd_pops - rp != 4 || pending !== 4'd4) begin
            errors++;
            $display("FAIL cap_count: got %0d reads pending=%0d required 4 reads pending=4", m_rd_pops - rp, pending);
        end
        for (int k = 0; k < 6; k++) begin
            m_readdata      = 32'(32'hFEFEFEFE - k);
            m_readdatavalid = 1'b1;
            cyc();
            m_readdatavalid = 1'b0;
            repeat (3) cyc();
        end
        checks++;
        if (s_rdv_cnt - rc != 6 || m_rd_pops - rp != 6 || pending !== 4'd0) begin
            errors++;
            $display("FAIL cap_drain: got %0d responses %0d reads pending=%0d required 6 6 0",
                     s_rdv_cnt - rc, m_rd_pops - rp, pending);
        end
    endtask

    task automatic test_simultaneous();
        m_waitrequest = 1'b0;
        send(1'b1, 1'b0, 32'h3000, 32'h0);
        send(1'b1, 1'b0, 32'h3004, 32'h0);
        repeat (3) cyc();
        m_waitrequest = 1'b1;
        send(1'b1, 1'b0, 32'h3008, 32'h0);
        repeat (2) cyc();
        checks++;
        if (m_read !== 1'b1 || pending !== 4'd2) begin
            errors++;
            $display("FAIL simul_setup: got m_read %b pending %0d required 1 and 2", m_read, pending);
        end
        m_waitrequest   = 1'b0;
        m_readdata      = 32'h5A5A0001;
        m_readdatavalid = 1'b1;
        cyc();
        m_readdatavalid = 1'b0;
        checks++;
        if (pending !== 4'd2 || m_read !== 1'b0) begin
            errors++;
            $display("FAIL simul_pending: got pending %0d m_read %b required 2 and 0", pending, m_read);
        end
        for (int k = 2; k <= 3; k++) begin
            m_readdata      = 32'(32'h5A5A0000 + k);
            m_readdatavalid = 1'b1;
            cyc();
            m_readdatavalid = 1'b0;
            cyc();
        end
        checks++;
        if (pending !== 4'd0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL simul_drain: got pending %0d queued %0d required 0 0", pending, rsp_q.size());
        end
    endtask

    task automatic test_illegal();
        m_waitrequest = 1'b0;
        send(1'b1, 1'b1, 32'h4000, 32'hBAD0BAD0);
        checks++;
        if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 32'h4000 || err_stale !== 1'b1) begin
            errors++;
            $display("FAIL illegal_rw: got wr=%b rd=%b addr %h err=%b required wr=1 rd=0 addr 4000 err=1",
                     m_write, m_read, m_address, err_stale);
        end
        repeat (2) cyc();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_stale();
        checks++;
        if (pending !== 4'd0 || err_stale !== 1'b0) begin
            errors++;
            $display("FAIL stale_pre: got pending %0d err %b required 0 0", pending, err_stale);
        end
        m_readdata      = 32'hDEAD0000;
        m_readdatavalid = 1'b1;
        cyc();
        m_readdatavalid = 1'b0;
        checks++;
        if (s_readdatavalid !== 1'b0 || err_stale !== 1'b1 || pending !== 4'd0) begin
            errors++;
            $display("FAIL stale_drop: got rdv %b err %b pending %0d required 0 1 0",
                     s_readdatavalid, err_stale, pending);
        end
        cyc();
        checks++;
        if (s_readdatavalid !== 1'b0 || err_stale !== 1'b1) begin
            errors++;
            $display("FAIL stale_sticky: got rdv %b err %b required 0 1", s_readdatavalid, err_stale);
        end
    endtask

    task automatic test_reset_midop();
        int wp;
        m_waitrequest = 1'b1;
        send(1'b0, 1'b1, 32'h5000, 32'h11110000);
        send(1'b0, 1'b1, 32'h5004, 32'h11110004);
        checks++;
        if (s_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL midop_full: got waitrequest %b required 1", s_waitrequest);
        end
        wp  = m_wr_pops;
        rst = 1'b1;
        cyc();
        rst           = 1'b0;
        m_waitrequest = 1'b0;
        checks++;
        if (err_stale !== 1'b0 || pending !== 4'd0) begin
            errors++;
            $display("FAIL midop_clear: got err %b pending %0d required 0 0", err_stale, pending);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (m_write !== 1'b0 || m_read !== 1'b0) begin
                errors++;
                $display("FAIL midop_discard: cycle %0d got wr=%b rd=%b addr %h required no command",
                         i, m_write, m_read, m_address);
            end
            cyc();
        end
        checks++;
        if (m_wr_pops != wp) begin
            errors++;
            $display("FAIL midop_count: got %0d writes issued required 0", m_wr_pops - wp);
        end
    endtask

    initial begin
        rst             = 1'b1;
        s_read          = 1'b0;
        s_write         = 1'b0;
        s_address       = '0;
        s_writedata     = '0;
        m_waitrequest   = 1'b0;
        m_readdata      = '0;
        m_readdatavalid = 1'b0;

        test_reset();
        test_single_write();
        test_sdram_stall();
        test_pending_cap();
        test_simultaneous();
        test_illegal();
        apply_reset();
        test_stale();
        test_reset_midop();

        checks++;
        if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queues: got %0d commands %0d responses left required 0 0", cmd_q.size(), rsp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
